// File: rtl/mul32_issue.sv
// Issue/retire controller around the pipelined mul32p multiplier: registers operands,
// tracks op metadata alongside the multiplier pipeline and queues results under credit control.
module mul32_issue #(
    parameter int LAT        = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    output logic [1:0]       mul_mode,
    input  logic [31:0]      mul_lo,
    input  logic [31:0]      mul_hi,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = 32 + TAG_W;

    logic            accept;
    logic            pop;
    logic            push;
    logic [1:0]      mode_sel;
    logic [CW-1:0]   credits_reg;
    logic [CW-1:0]   credits_next;

    // Request metadata rides with the operand register, then through LAT stages matching mul32p.
    logic             iss_valid_reg;
    logic             iss_sel_reg;
    logic [TAG_W-1:0] iss_tag_reg;

    logic [LAT-1:0]   dl_valid_reg;
    logic [LAT-1:0]   dl_sel_reg;
    logic [TAG_W-1:0] dl_tag_reg [LAT];

    logic [EW-1:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic [EW-1:0]    push_word;

    assign req_ready = (credits_reg != '0);
    assign accept    = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready;

    // MUL only needs the low word, which is identical in every signedness mode.
    always_comb begin
        mode_sel = 2'b01;
        case (req_op)
            2'b00:   mode_sel = 2'b01;
            2'b01:   mode_sel = 2'b01;
            2'b10:   mode_sel = 2'b10;
            default: mode_sel = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a         <= '0;
            mul_b         <= '0;
            mul_mode      <= 2'b00;
            iss_valid_reg <= 1'b0;
            iss_sel_reg   <= 1'b0;
            iss_tag_reg   <= '0;
        end else begin
            iss_valid_reg <= accept;
            if (accept) begin
                mul_a       <= req_a;
                mul_b       <= req_b;
                mul_mode    <= mode_sel;
                iss_sel_reg <= (req_op != 2'b00);
                iss_tag_reg <= req_tag;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_dl
            logic             valid_in;
            logic             sel_in;
            logic [TAG_W-1:0] tag_in;

            if (gi == 0) begin : g_src
                assign valid_in = iss_valid_reg;
                assign sel_in   = iss_sel_reg;
                assign tag_in   = iss_tag_reg;
            end else begin : g_src
                assign valid_in = dl_valid_reg[gi-1];
                assign sel_in   = dl_sel_reg[gi-1];
                assign tag_in   = dl_tag_reg[gi-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dl_valid_reg[gi] <= 1'b0;
                    dl_sel_reg[gi]   <= 1'b0;
                    dl_tag_reg[gi]   <= '0;
                end else begin
                    dl_valid_reg[gi] <= valid_in;
                    dl_sel_reg[gi]   <= sel_in;
                    dl_tag_reg[gi]   <= tag_in;
                end
            end
        end
    endgenerate

    assign push      = dl_valid_reg[LAT-1];
    assign push_word = {(dl_sel_reg[LAT-1] ? mul_hi : mul_lo), dl_tag_reg[LAT-1]};

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_word;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_comb begin
        credits_next = credits_reg;
        if (accept && !pop) begin
            credits_next = credits_reg - 1'b1;
        end else if (pop && !accept) begin
            credits_next = credits_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            credits_reg <= CW'(FIFO_DEPTH);
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg   <= count_next;
            credits_reg <= credits_next;
        end
    end

    assign rsp_valid           = (count_reg != '0);
    assign {rsp_data, rsp_tag} = fifo_mem[rd_ptr_reg];
    assign busy                = (|dl_valid_reg) | iss_valid_reg | (count_reg != '0);

    // Credits reserve a FIFO slot for every issued op, so a push can never meet a full FIFO.
    push_never_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count_reg == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_mul32_issue.sv
// Bench for mul32_issue: a behavioural mul32p stand-in, directed vectors from known products,
// and a queue scoreboard fed by random traffic.
module tb_mul32_issue;

    localparam int LAT   = 8;
    localparam int DEPTH = 8;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'b00;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic [1:0]       mul_mode;
    logic [31:0]      mul_lo;
    logic [31:0]      mul_hi;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;

    always #5 clk = ~clk;

    mul32_issue #(.LAT(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .mul_a(mul_a), .mul_b(mul_b), .mul_mode(mul_mode),
        .mul_lo(mul_lo), .mul_hi(mul_hi),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .busy(busy)
    );

    // mul32p stand-in: product of the registered operands appears LAT edges later.
    logic [63:0] mp_pipe [LAT];

    function automatic logic [63:0] mp_product(input logic [31:0] a, input logic [31:0] b,
                                               input logic [1:0] mode);
        logic [63:0] ae;
        logic [63:0] be;
        ae = (mode == 2'b01 || mode == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        be = (mode == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        return ae * be;
    endfunction

    always @(posedge clk) begin
        mp_pipe[0] <= mp_product(mul_a, mul_b, mul_mode);
        for (int i = 1; i < LAT; i++) mp_pipe[i] <= mp_pipe[i-1];
    end
    assign mul_lo = mp_pipe[LAT-1][31:0];
    assign mul_hi = mp_pipe[LAT-1][63:32];

    // RISC-V result word from the op definition, using 64-bit integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            2'b00:   begin p = 64'(ua * ub); return p[31:0];  end
            2'b01:   begin p = 64'(sa * sb); return p[63:32]; end
            2'b10:   begin p = 64'(sa * ub); return p[63:32]; end
            default: begin p = 64'(ua * ub); return p[63:32]; end
        endcase
    endfunction

    int vec_count = 0;
    int miss_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_head;

    // Scoreboard: every accepted request yields exactly one in-order response.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    sb_head = exp_q.pop_front();
                    check("sb_data", rsp_data, sb_head.data);
                    check("sb_tag", 32'(rsp_tag), 32'(sb_head.tag));
                end
            end
            if (req_valid && req_ready) begin
                exp_q.push_back('{data: ref_result(req_op, req_a, req_b), tag: req_tag});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input int tag);
        req_valid = 1'b1;
        req_op    = 2'($urandom_range(0, 3));
        req_a     = $urandom;
        req_b     = $urandom;
        req_tag   = TAG_W'(tag);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic [1:0]  mode;
    } vec_t;

    vec_t vt [6];

    initial begin
        int n, acc, first_block, got, seen;

        vt[0] = '{op: 2'b11, a: 32'd292, b: 32'd6785, data: 32'd0, mode: 2'b00};
        vt[1] = '{op: 2'b00, a: 32'd292, b: 32'd6785, data: 32'd1981220, mode: 2'b01};
        vt[2] = '{op: 2'b01, a: 32'hFF439EB2, b: 32'd87654321, data: 32'hFFFC27C9, mode: 2'b01};
        vt[3] = '{op: 2'b00, a: 32'hFF439EB2, b: 32'd87654321, data: 32'd3642558226, mode: 2'b01};
        vt[4] = '{op: 2'b10, a: 32'hFECED300, b: 32'hFFFFFFFF, data: 32'hFECED300, mode: 2'b10};
        vt[5] = '{op: 2'b00, a: 32'hFECED300, b: 32'hFFFFFFFF, data: 32'd20000000, mode: 2'b01};

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_mul_a", mul_a, 32'd0);
        check("reset_mul_b", mul_b, 32'd0);
        check("reset_mul_mode", 32'(mul_mode), 32'd0);

        // Directed vectors: mode, latency, result and hold-under-stall.
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_op    = vt[i].op;
            req_a     = vt[i].a;
            req_b     = vt[i].b;
            req_tag   = TAG_W'(i + 3);
            tick();
            req_valid = 1'b0;
            check("vec_mode", 32'(mul_mode), 32'(vt[i].mode));
            check("vec_mul_a", mul_a, vt[i].a);
            n = 0;
            while (!rsp_valid && n < 40) begin
                tick();
                n++;
            end
            check("vec_latency", 32'(n), 32'(LAT + 1));
            check("vec_data", rsp_data, vt[i].data);
            check("vec_tag", 32'(rsp_tag), 32'(i + 3));
            tick();
            tick();
            check("vec_hold", rsp_data, vt[i].data);
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check("vec_popped", 32'(rsp_valid), 32'd0);
            $display("vector %0d op=%0d data=0x%08h latency=%0d", i, vt[i].op, vt[i].data, n);
        end

        // Backpressure: ten back-to-back requests with the response side stalled.
        acc = 0;
        first_block = -1;
        for (int i = 0; i < 10; i++) begin
            drive_rand(i);
            if (req_ready) acc++;
            else if (first_block < 0) first_block = i;
            tick();
        end
        req_valid = 1'b0;
        check("bp_accepted", 32'(acc), 32'd8);
        check("bp_first_block", 32'(first_block), 32'd8);
        repeat (LAT + 3) tick();
        check("bp_full_valid", 32'(rsp_valid), 32'd1);
        check("bp_full_ready", 32'(req_ready), 32'd0);
        check("bp_full_busy", 32'(busy), 32'd1);
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            if (rsp_valid) begin
                check("bp_order", 32'(rsp_tag), 32'(got));
                got++;
            end
            tick();
        end
        rsp_ready = 1'b0;
        check("bp_drained", 32'(got), 32'd8);
        check("bp_credits_back", 32'(req_ready), 32'd1);
        check("bp_idle", 32'(busy), 32'd0);
        $display("backpressure accepted=%0d drained=%0d", acc, got);

        // Refill to full, then stream with pops: one pop and one accept per cycle while draining.
        acc = 0;
        for (int c = 0; c < 20 && acc < 8; c++) begin
            drive_rand(c);
            if (req_ready) acc++;
            tick();
        end
        req_valid = 1'b0;
        check("refill_accepted", 32'(acc), 32'd8);
        repeat (LAT + 3) tick();
        check("refill_full", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        drive_rand(0);
        tick();
        for (int c = 0; c < 8; c++) begin
            check("stream_ready", 32'(req_ready), 32'd1);
            drive_rand(c + 1);
            tick();
        end
        for (int c = 0; c < 60; c++) begin
            drive_rand(c);
            req_valid = 1'($urandom_range(0, 3) != 0);
            rsp_ready = 1'($urandom_range(0, 2) != 0);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("soak_idle", 32'(busy), 32'd0);
        check("soak_sb_empty", 32'(exp_q.size()), 32'd0);
        rsp_ready = 1'b0;
        $display("random soak drained in %0d cycles", n);

        // Reset mid-operation: 3 queued, 5 in flight.
        for (int i = 0; i < 3; i++) begin
            drive_rand(i);
            tick();
        end
        req_valid = 1'b0;
        repeat (LAT + 3) tick();
        for (int i = 0; i < 5; i++) begin
            drive_rand(i + 3);
            tick();
        end
        req_valid = 1'b0;
        check("pre_reset_valid", 32'(rsp_valid), 32'd1);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_mul_a", mul_a, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 2 * LAT; c++) begin
            tick();
            if (rsp_valid) seen++;
        end
        check("rst_no_response", 32'(seen), 32'd0);
        check("rst_idle_busy", 32'(busy), 32'd0);
        $display("reset mid-operation: responses after reset=%0d", seen);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
